// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV-M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic is_signed_a(input md_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: magnitudes, result signs and the
// divide-by-zero / signed-overflow shortcuts that bypass iteration.
module muldiv_operand_prep import muldiv_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg_result,
    output logic            neg_rem,
    output logic            special,
    output logic [XLEN-1:0] special_result
);

    md_op_e op;
    logic   a_neg;
    logic   b_neg;
    logic   div_by_zero;
    logic   signed_ovf;
    logic   want_rem;

    always_comb begin
        op          = md_op_e'(funct);
        a_neg       = is_signed_a(op) && src_a[XLEN-1];
        b_neg       = is_signed_b(op) && src_b[XLEN-1];
        mag_a       = a_neg ? -src_a : src_a;
        mag_b       = b_neg ? -src_b : src_b;
        neg_result  = a_neg ^ b_neg;
        neg_rem     = a_neg;
        want_rem    = (op == OP_REM) || (op == OP_REMU);
        div_by_zero = (src_b == '0);
        signed_ovf  = is_signed_b(op) && is_div(op)
                      && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        special     = is_div(op) && (div_by_zero || signed_ovf);
        // Divide-by-zero takes precedence: -2^(XLEN-1)/0 is a zero divide.
        if (div_by_zero) begin
            special_result = want_rem ? src_a : '1;
        end else begin
            special_result = want_rem ? '0 : src_a;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV-M multiply/divide unit for the Execute stage.
// Optional macro MULDIV_EARLY_OUT_EN: MUL stops once the remaining multiplier bits are zero.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [2:0]      FunctE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);

    localparam int              CNT_W     = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;

    logic [XLEN-1:0]   mag_a, mag_b, special_result;
    logic              neg_result, neg_rem, special;
    logic              mul_last;
    logic [XLEN:0]     rem_shift, diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .funct          (FunctE),
        .src_a          (SrcAE),
        .src_b          (SrcBE),
        .mag_a          (mag_a),
        .mag_b          (mag_b),
        .neg_result     (neg_result),
        .neg_rem        (neg_rem),
        .special        (special),
        .special_result (special_result)
    );

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_last = (cnt_q == LAST_ITER) || (opb_q[XLEN-1:1] == '0);
`else
    assign mul_last = (cnt_q == LAST_ITER);
`endif

    // Accumulator is shared: MUL keeps the product, DIV keeps {remainder, quotient}.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        opb_d     = opb_q;
        result_d  = result_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        rem_shift = acc_q[2*XLEN-1:XLEN-1];
        diff      = rem_shift - {1'b0, opb_q};
        prod      = '0;
        quo_fix   = '0;
        rem_fix   = '0;
        case (state_q)
            ST_IDLE: begin
                if (StartE && !FlushE) begin
                    op_d      = md_op_e'(FunctE);
                    cnt_d     = '0;
                    neg_d     = neg_result;
                    neg_rem_d = neg_rem;
                    opb_d     = mag_b;
                    if (special) begin
                        state_d  = ST_DONE;
                        result_d = special_result;
                    end else if (is_div(md_op_e'(FunctE))) begin
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        state_d = ST_DIV;
                    end else begin
                        acc_d   = '0;
                        mcand_d = {{XLEN{1'b0}}, mag_a};
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                if (opb_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (mul_last) begin
                    prod     = neg_q ? -acc_d : acc_d;
                    result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    state_d  = ST_DONE;
                end
            end
            ST_DIV: begin
                if (rem_shift >= {1'b0, opb_q}) begin
                    acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    quo_fix  = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
                    rem_fix  = neg_rem_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
                    result_d = ((op_q == OP_REM) || (op_q == OP_REMU)) ? rem_fix : quo_fix;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A flush abandons whatever is in flight and keeps the last published result.
        if (FlushE) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign BusyE   = ((state_q == ST_IDLE) && StartE && !FlushE && !rst)
                     || (state_q == ST_MUL) || (state_q == ST_DIV);
    assign DoneE   = (state_q == ST_DONE);
    assign ResultE = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV-M multiply/divide unit that sits in the Execute stage beside the single-cycle ALU, with its width set by XLEN. It accepts operands already forwarded into SrcAE/SrcBE. It holds the pipeline through BusyE until the result is ready, then presents ResultE with a one-cycle DoneE. The unit is flushable by the hazard unit, exactly like the E pipeline register.

Parameters:
XLEN, 32, operand/result width; legal range 8..64.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
StartE  input  1  M-extension instruction present in E; sampled only in IDLE
FlushE  input  1  abort current operation; priority over StartE
FunctE  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcAE  input  XLEN  rs1 operand (dividend / multiplicand)
SrcBE  input  XLEN  rs2 operand (divisor / multiplier)
BusyE  output  1  stall request to hazard unit (drives StallF/StallD, holds E)
DoneE  output  1  ResultE valid this cycle (single-cycle pulse)
ResultE  output  XLEN  registered result, held until next completion

Behaviour:
- States: IDLE, MUL, DIV, DONE. Iteration counter is $clog2(XLEN+1) bits wide.
- Reset: state=IDLE, ResultE=0, DoneE=0, BusyE=0. Reset mid-operation discards the operation and leaves no Done pulse.
- Start accept (cycle t, IDLE, StartE=1, FlushE=0):
  - Operands and FunctE are latched.
  - For signed modes, operands are converted to magnitudes and the result sign is recorded.
  - Next state is MUL for FunctE[2]=0, DIV for FunctE[2]=1.
- BusyE is combinational:
  - 1 when (IDLE & StartE & ~FlushE & ~rst) or state is MUL/DIV.
  - 0 in DONE and IDLE otherwise.
- MUL state:
  - Radix-2 shift-add, one multiplier bit per cycle, on a 2*XLEN accumulator.
  - Runs XLEN cycles (t+1..t+XLEN), then goes to DONE.
- DIV state:
  - Restoring division, one quotient bit per cycle.
  - Runs XLEN cycles, then goes to DONE.
- DONE (t+XLEN+1):
  - DoneE=1 and BusyE=0, so the pipeline advances and captures ResultE.
  - Next state is IDLE. StartE is ignored in DONE, because it still reflects the completing instruction.
- Result selection (sign-corrected on the transition into DONE):
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits. Signedness is (s,s) / (s,u) / (u,u).
  - DIV/DIVU: quotient. REM/REMU: remainder; remainder sign follows the dividend.
- Special cases go IDLE->DONE directly (DoneE at t+1; BusyE high only in cycle t):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = dividend; remainder = 0.
- FlushE in any state:
  - Next state is IDLE and no DoneE follows. ResultE keeps its previous value.
  - FlushE with StartE in IDLE: the start is ignored.
  - FlushE in DONE: DoneE is still 1 in that cycle; the pipeline discards the result.
- ResultE changes only on entry to DONE.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: the MUL state exits when the remaining multiplier magnitude bits are all zero, with a minimum of 1 iteration. Latency is n = max(1, index of MSB of |SrcBE| + 1); DoneE at t+n+1. DIV timing is unchanged.
- Undefined: MUL always takes XLEN iterations.
- Results are identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - enum md_op_e (8 funct3 codes);
  - enum md_state_e (IDLE/MUL/DIV/DONE);
  - helper functions is_signed_a/is_signed_b/is_div.
- Sub-module muldiv_operand_prep (combinational): magnitude conversion, result-sign computation and special-case detection, shared by MUL and DIV paths.

Test Plan (XLEN=32, start at cycle t):
- MUL 7 * 0xFFFFFFFD -> ResultE=0xFFFFFFEB; BusyE high t..t+32; DoneE only at t+33.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each DoneE at t+33.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, DoneE at t+1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, DoneE at t+1.
- FlushE at t+10 during DIV -> IDLE at t+11, no DoneE, ResultE unchanged. New MUL 3*4 started at t+11 -> 12 at t+44. rst at t+5 of another op -> IDLE, ResultE=0, no DoneE.
- With MULDIV_EARLY_OUT_EN: MUL 5*3 -> 15 with DoneE at t+3; MUL 9*0 -> 0 with DoneE at t+2. Without the macro both complete at t+33.
